// File: rtl/matvec_engine.sv
// Matrix-vector multiply engine: fetches B and the ROWS rows of A over an
// Avalon-MM read port, then runs ROWS parallel unsigned MACs for COLS cycles.
module matvec_engine #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    output logic [ADDR_WIDTH-1:0]      address,
    output logic                       read,
    input  logic [COLS*DATA_WIDTH-1:0] readdata,
    input  logic                       readdatavalid,
    input  logic                       waitrequest,
    output logic                       busy,
    output logic                       done,
    output logic [ROWS*ACC_WIDTH-1:0]  result
);

    localparam int IDX_W  = $clog2(ROWS + 1);
    localparam int K_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W  = COLS * DATA_WIDTH;
    localparam int PROD_W = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RESP = 3'd2,
        S_CALC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Product is zero-extended or truncated to the accumulator width.
    function automatic logic [ACC_WIDTH-1:0] fit_acc(input logic [PROD_W-1:0] p);
        logic [PROD_W+ACC_WIDTH-1:0] wide;
        wide = {{ACC_WIDTH{1'b0}}, p};
        return wide[ACC_WIDTH-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] elem(input logic [ROW_W-1:0] row,
                                                   input logic [K_W-1:0]   k);
        return row[k*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    function automatic logic [ACC_WIDTH-1:0] mac(input logic [ACC_WIDTH-1:0]  acc,
                                                 input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(a) * PROD_W'(b);
        return acc + fit_acc(prod);
    endfunction

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [ROW_W-1:0]        b_q, b_d;
    logic [ROW_W-1:0]        a_q [ROWS];
    logic [ROW_W-1:0]        a_d [ROWS];
    logic [ACC_WIDTH-1:0]    acc_q [ROWS];
    logic [ACC_WIDTH-1:0]    acc_d [ROWS];
    logic [ROWS*ACC_WIDTH-1:0] result_q, result_d;
    logic [ADDR_WIDTH-1:0]   address_q, address_d;
    logic                    read_q, read_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // Next-state, fetch bookkeeping and MAC datapath.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        idx_d     = idx_q;
        k_d       = k_q;
        b_d       = b_q;
        a_d       = a_q;
        acc_d     = acc_q;
        result_d  = result_q;
        address_d = address_q;
        read_d    = read_q;
        busy_d    = busy_q;
        done_d    = done_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    base_d    = base_addr;
                    idx_d     = '0;
                    k_d       = '0;
                    for (int r = 0; r < ROWS; r++) begin
                        acc_d[r] = '0;
                    end
                    result_d  = '0;
                    address_d = base_addr;
                    read_d    = 1'b1;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    state_d   = S_REQ;
                end else begin
                    state_d = state_q;
                end
            end
            S_REQ: begin
                if (!waitrequest) begin
                    read_d  = 1'b0;
                    state_d = S_RESP;
                end else begin
                    read_d  = 1'b1;
                end
            end
            S_RESP: begin
                if (readdatavalid) begin
                    if (idx_q == IDX_W'(0)) begin
                        b_d = readdata;
                    end else begin
                        for (int r = 0; r < ROWS; r++) begin
                            if (idx_q == IDX_W'(r + 1)) begin
                                a_d[r] = readdata;
                            end else begin
                                a_d[r] = a_q[r];
                            end
                        end
                    end
                    if (idx_q == IDX_W'(ROWS)) begin
                        k_d     = '0;
                        state_d = S_CALC;
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        address_d = base_q + ADDR_WIDTH'(idx_q) + ADDR_WIDTH'(1);
                        read_d    = 1'b1;
                        state_d   = S_REQ;
                    end
                end else begin
                    state_d = S_RESP;
                end
            end
            S_CALC: begin
                for (int r = 0; r < ROWS; r++) begin
                    acc_d[r] = mac(acc_q[r], elem(a_q[r], k_q), elem(b_q, k_q));
                end
                // The final MAC's sum goes straight to the result on the same edge.
                if (k_q == K_W'(COLS - 1)) begin
                    for (int r = 0; r < ROWS; r++) begin
                        result_d[r*ACC_WIDTH +: ACC_WIDTH] = acc_d[r];
                    end
                    k_d     = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            default: begin
                read_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            idx_q     <= '0;
            k_q       <= '0;
            b_q       <= '0;
            for (int r = 0; r < ROWS; r++) begin
                a_q[r]   <= '0;
                acc_q[r] <= '0;
            end
            result_q  <= '0;
            address_q <= '0;
            read_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            idx_q     <= idx_d;
            k_q       <= k_d;
            b_q       <= b_d;
            for (int r = 0; r < ROWS; r++) begin
                a_q[r]   <= a_d[r];
                acc_q[r] <= acc_d[r];
            end
            result_q  <= result_d;
            address_q <= address_d;
            read_q    <= read_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign address = address_q;
    assign read    = read_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;

endmodule
